execute_stage: RTL and testbench
================================

# execute_stage

Execute stage of the MIPS-DLX pipeline, directly downstream of instruction decode. It consumes the decoded control fields, register operands, sign-extended immediate and PC+1, and performs the ALU operation and branch resolution. Results are registered into the EX/MEM boundary. Multiply is iterative and multi-cycle: the block back-pressures upstream while it runs.

## Interface
- No parameters; all widths are fixed.
- clock  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- id_valid  in  1  decode presents a valid instruction this cycle.
- EX_control  in  4  [3] ALUSrc (1 = immed_ext as operand B, 0 = busb); [2:0] ALUop.
- M_control  in  4  memory control; [0] is BOP (branch-on-equal).
- WB_control  in  2  write-back control, passed through.
- busa  in  32  operand A.
- busb  in  32  register B; also store data.
- immed_ext  in  32  sign-extended immediate.
- PC_plus_1  in  10  word address of the next instruction.
- rd_in  in  5  destination register.
- flush  in  1  synchronous kill of the instruction in flight.
- stall_out  out  1  busy; decode must hold its outputs.
- ex_valid  out  1  EX/MEM register holds a valid instruction.
- alu_result  out  32  ALU result.
- store_data  out  32  registered busb.
- rd_out  out  5  registered rd_in.
- ex_M_control  out  4  registered M_control; zero on bubble.
- ex_WB_control  out  2  registered WB_control; zero on bubble.
- branch_taken  out  1  branch resolved as taken.
- branch_target  out  10  registered PC_plus_1 + immed_ext[9:0], modulo 1024.

## Operation
- Operand B = EX_control[3] ? immed_ext : busb.
- ALUop encodings:
  - 000 ADD; 001 SUB; 010 AND; 011 OR; 100 XOR.
  - 101 SLT: signed A<B, giving 1, else 0.
  - 110 SLL: A << B[4:0].
  - 111 MUL: low 32 bits of A*B.
  - ADD, SUB and MUL wrap mod 2^32; overflow is not flagged.
- Branch: branch_taken = M_control[0] & (busa == busb), registered with the instruction. branch_target is always computed.
- FSM states:
  - IDLE: accepts when id_valid=1 and flush=0.
    - Non-MUL: EX/MEM register loaded, ex_valid=1.
    - MUL: latch A, B, control and rd; clear the accumulator and the 5-bit counter; go to BUSY; ex_valid=0.
  - BUSY: one shift-add step per cycle: if B[cnt], acc += A << cnt. Inputs are ignored. After the 32nd step, load the EX/MEM register with acc and the latched fields, set ex_valid=1, return to IDLE.
- Bubble: id_valid=0 in IDLE, or any BUSY cycle before completion.
  - ex_valid=0; ex_M_control, ex_WB_control and branch_taken are 0.
  - alu_result, store_data, rd_out and branch_target hold.
- flush (priority below reset, above everything else):
  - At the next edge: ex_valid=0, controls zeroed, branch_taken=0.
  - BUSY aborts to IDLE with no result.
  - An instruction presented in the same cycle is dropped.

## Timing
- Reset: all outputs 0; state IDLE; counter and accumulator 0. Takes effect immediately, including mid-multiply.
- Non-MUL latency is 1: accepted at edge E0, results visible after E0.
- MUL: accepted at E0.
  - stall_out=1 (registered) from after E0 through E32: exactly 32 cycles.
  - At E32: result written, ex_valid=1, stall_out=0.
  - A new instruction is accepted at E33 at the earliest.
- stall_out is 0 in IDLE. No combinational path exists from any input to stall_out.
- Back-to-back non-MUL instructions are accepted every cycle.

## Test plan
- ADD: busa=5, busb=7, EX_control=0000, id_valid=1 -> next cycle alu_result=12, ex_valid=1, stall_out=0.
- Immediate/SLT: busa=3, immed_ext=0xFFFFFFFF, EX_control=1001 -> alu_result=4. Then busa=0xFFFFFFFF, busb=1, EX_control=0101 -> alu_result=1.
- MUL: busa=0x00010000, busb=0x00010001, EX_control=0111 -> stall_out high exactly 32 cycles, ex_valid=0 meanwhile, then alu_result=0x00010000, ex_valid=1 for one cycle.
- Branch: M_control=0001, busa=busb=9, PC_plus_1=1020, immed_ext=8 -> branch_taken=1, branch_target=4 (wrap). With busb=10 -> branch_taken=0, branch_target=4.
- Flush during MUL at BUSY cycle 10 -> stall_out=0 after the next edge, ex_valid stays 0, no MUL result ever appears. An ADD presented next completes normally.
- Reset asserted mid-MUL with ex_valid=1 from a prior op -> all outputs 0 asynchronously. After release, the first ADD completes with latency 1.

Source files
------------

// File: rtl/execute_stage.sv
// EX stage of the DLX pipeline: single-cycle ALU and branch resolution, plus a
// 32-step iterative shift-add multiplier that holds decode via stall_out.
module execute_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [3:0]  EX_control,
    input  logic [3:0]  M_control,
    input  logic [1:0]  WB_control,
    input  logic [31:0] busa,
    input  logic [31:0] busb,
    input  logic [31:0] immed_ext,
    input  logic [9:0]  PC_plus_1,
    input  logic [4:0]  rd_in,
    input  logic        flush,
    output logic        stall_out,
    output logic        ex_valid,
    output logic [31:0] alu_result,
    output logic [31:0] store_data,
    output logic [4:0]  rd_out,
    output logic [3:0]  ex_M_control,
    output logic [1:0]  ex_WB_control,
    output logic        branch_taken,
    output logic [9:0]  branch_target
);
    // Handshake: decode holds its outputs while stall_out=1; an instruction is
    // taken at a rising edge when id_valid=1, flush=0 and stall_out=0.
    // ex_valid marks one cycle of valid EX/MEM contents per accepted instruction.

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLT = 3'd5;
    localparam logic [2:0] OP_SLL = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    state_t      state;
    logic [4:0]  cnt;
    logic [31:0] acc;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [31:0] mul_store;
    logic [3:0]  mul_m;
    logic [1:0]  mul_wb;
    logic [4:0]  mul_rd;
    logic        mul_br;
    logic [9:0]  mul_tgt;

    logic [31:0] op_b;
    logic [31:0] alu_out;
    logic [31:0] acc_next;
    logic        br_eq;
    logic [9:0]  tgt_sum;

    assign op_b     = EX_control[3] ? immed_ext : busb;
    assign br_eq    = M_control[0] & (busa == busb);
    assign tgt_sum  = PC_plus_1 + immed_ext[9:0];
    assign acc_next = mul_b[cnt] ? acc + (mul_a << cnt) : acc;

    always_comb begin
        alu_out = '0;
        case (EX_control[2:0])
            OP_ADD:  alu_out = busa + op_b;
            OP_SUB:  alu_out = busa - op_b;
            OP_AND:  alu_out = busa & op_b;
            OP_OR:   alu_out = busa | op_b;
            OP_XOR:  alu_out = busa ^ op_b;
            OP_SLT:  alu_out = {31'd0, $signed(busa) < $signed(op_b)};
            OP_SLL:  alu_out = busa << op_b[4:0];
            default: alu_out = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            stall_out     <= 1'b0;
            cnt           <= '0;
            acc           <= '0;
            mul_a         <= '0;
            mul_b         <= '0;
            mul_store     <= '0;
            mul_m         <= '0;
            mul_wb        <= '0;
            mul_rd        <= '0;
            mul_br        <= 1'b0;
            mul_tgt       <= '0;
            ex_valid      <= 1'b0;
            alu_result    <= '0;
            store_data    <= '0;
            rd_out        <= '0;
            ex_M_control  <= '0;
            ex_WB_control <= '0;
            branch_taken  <= 1'b0;
            branch_target <= '0;
        end else begin
            // Bubble by default; data fields hold their last values.
            ex_valid      <= 1'b0;
            ex_M_control  <= '0;
            ex_WB_control <= '0;
            branch_taken  <= 1'b0;
            if (flush) begin
                state     <= IDLE;
                stall_out <= 1'b0;
                cnt       <= '0;
            end else if (state == IDLE) begin
                if (id_valid) begin
                    if (EX_control[2:0] == OP_MUL) begin
                        mul_a     <= busa;
                        mul_b     <= op_b;
                        mul_store <= busb;
                        mul_m     <= M_control;
                        mul_wb    <= WB_control;
                        mul_rd    <= rd_in;
                        mul_br    <= br_eq;
                        mul_tgt   <= tgt_sum;
                        acc       <= '0;
                        cnt       <= '0;
                        state     <= BUSY;
                        stall_out <= 1'b1;
                    end else begin
                        ex_valid      <= 1'b1;
                        alu_result    <= alu_out;
                        store_data    <= busb;
                        rd_out        <= rd_in;
                        ex_M_control  <= M_control;
                        ex_WB_control <= WB_control;
                        branch_taken  <= br_eq;
                        branch_target <= tgt_sum;
                    end
                end
            end else begin
                acc <= acc_next;
                cnt <= cnt + 5'd1;
                // Step 31 is the last partial product; publish acc_next directly.
                if (cnt == 5'd31) begin
                    state         <= IDLE;
                    stall_out     <= 1'b0;
                    ex_valid      <= 1'b1;
                    alu_result    <= acc_next;
                    store_data    <= mul_store;
                    rd_out        <= mul_rd;
                    ex_M_control  <= mul_m;
                    ex_WB_control <= mul_wb;
                    branch_taken  <= mul_br;
                    branch_target <= mul_tgt;
                end
            end
        end
    end
endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: directed scenarios plus random traffic
// checked against an arithmetic reference model.
module tb_execute_stage;
    localparam int W = 86;

    logic        clock = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [3:0]  EX_control;
    logic [3:0]  M_control;
    logic [1:0]  WB_control;
    logic [31:0] busa;
    logic [31:0] busb;
    logic [31:0] immed_ext;
    logic [9:0]  PC_plus_1;
    logic [4:0]  rd_in;
    logic        flush;
    logic        stall_out;
    logic        ex_valid;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  rd_out;
    logic [3:0]  ex_M_control;
    logic [1:0]  ex_WB_control;
    logic        branch_taken;
    logic [9:0]  branch_target;

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass = 0;

    always #5 clock = ~clock;

    execute_stage dut (
        .clock(clock), .reset(reset), .id_valid(id_valid), .EX_control(EX_control),
        .M_control(M_control), .WB_control(WB_control), .busa(busa), .busb(busb),
        .immed_ext(immed_ext), .PC_plus_1(PC_plus_1), .rd_in(rd_in), .flush(flush),
        .stall_out(stall_out), .ex_valid(ex_valid), .alu_result(alu_result),
        .store_data(store_data), .rd_out(rd_out), .ex_M_control(ex_M_control),
        .ex_WB_control(ex_WB_control), .branch_taken(branch_taken),
        .branch_target(branch_target)
    );

    wire [W-1:0] out_vec = {alu_result, store_data, rd_out, ex_M_control,
                            ex_WB_control, branch_taken, branch_target};

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: condition not met", name);
    endtask

    // Reference: results from the instruction-set rules, MUL as a plain product.
    function automatic logic [W-1:0] model(input logic [3:0] exc, input logic [3:0] mc,
                                           input logic [1:0] wbc, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] imm,
                                           input logic [9:0] pc, input logic [4:0] rd);
        logic [31:0] opb;
        logic [31:0] r;
        logic [9:0]  tgt;
        opb = exc[3] ? imm : b;
        case (exc[2:0])
            3'd0: r = a + opb;
            3'd1: r = a - opb;
            3'd2: r = a & opb;
            3'd3: r = a | opb;
            3'd4: r = a ^ opb;
            3'd5: r = ($signed(a) < $signed(opb)) ? 32'd1 : 32'd0;
            3'd6: r = a << opb[4:0];
            default: r = 32'(longint'(a) * longint'(opb));
        endcase
        tgt = 10'((int'(pc) + int'(imm[9:0])) % 1024);
        return {r, b, rd, mc, wbc, mc[0] && (a == b), tgt};
    endfunction

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic send(input logic [3:0] exc, input logic [3:0] mc, input logic [1:0] wbc,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                        input logic [9:0] pc, input logic [4:0] rd);
        int guard = 0;
        while (stall_out && guard < 64) begin
            @(negedge clock);
            guard++;
        end
        if (stall_out) fail_now("stall_timeout");
        id_valid = 1'b1; EX_control = exc; M_control = mc; WB_control = wbc;
        busa = a; busb = b; immed_ext = imm; PC_plus_1 = pc; rd_in = rd;
        exp_q.push_back(model(exc, mc, wbc, a, b, imm, pc, rd));
        @(negedge clock);
        id_valid = 1'b0;
        if (exc[2:0] != 3'd7) check("latency1", 128'({ex_valid, stall_out}), 128'(2'b10));
        else check("mul_stall_start", 128'({ex_valid, stall_out}), 128'(2'b01));
    endtask

    initial begin : monitor
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (ex_valid) begin
                    if (exp_q.size() == 0) fail_now("unexpected_result");
                    else check("result", 128'(out_vec), 128'(exp_q.pop_front()));
                end else begin
                    check("bubble_ctrl", 128'({ex_M_control, ex_WB_control, branch_taken}), 128'(0));
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int n;
        logic [2:0] op;
        logic [31:0] a, b;
        reset = 1'b1; id_valid = 1'b0; flush = 1'b0; EX_control = '0; M_control = '0;
        WB_control = '0; busa = '0; busb = '0; immed_ext = '0; PC_plus_1 = '0; rd_in = '0;
        repeat (2) @(negedge clock);
        check("reset_outputs", 128'({out_vec, ex_valid, stall_out}), 128'(0));
        reset = 1'b0;
        @(negedge clock);

        // Directed ALU, immediate, SLT and branch cases.
        send(4'b0000, 4'b0000, 2'b00, 32'd5, 32'd7, 32'd0, 10'd0, 5'd1);
        send(4'b1001, 4'b0000, 2'b01, 32'd3, 32'd0, 32'hFFFF_FFFF, 10'd0, 5'd2);
        send(4'b0101, 4'b0000, 2'b01, 32'hFFFF_FFFF, 32'd1, 32'd0, 10'd0, 5'd3);
        send(4'b0000, 4'b0001, 2'b10, 32'd9, 32'd9, 32'd8, 10'd1020, 5'd4);
        send(4'b0000, 4'b0001, 2'b10, 32'd9, 32'd10, 32'd8, 10'd1020, 5'd5);
        send(4'b0110, 4'b0000, 2'b01, 32'h8000_0001, 32'd33, 32'd0, 10'd7, 5'd6);

        // Multiply: stall must last exactly 32 cycles with no valid output.
        send(4'b0111, 4'b0010, 2'b11, 32'h0001_0000, 32'h0001_0001, 32'd0, 10'd100, 5'd7);
        n = 0;
        while (stall_out && n < 100) begin
            if (ex_valid) fail_now("mul_valid_during_busy");
            n++;
            @(negedge clock);
        end
        check("mul_stall_cycles", 128'(n), 128'(32));
        check("mul_done_valid", 128'(ex_valid), 128'(1));
        @(negedge clock);
        check("mul_valid_one_cycle", 128'(ex_valid), 128'(0));

        // Flush at BUSY cycle 10 aborts the multiply.
        send(4'b0111, 4'b0000, 2'b01, 32'd1234, 32'd5678, 32'd0, 10'd0, 5'd8);
        void'(exp_q.pop_back());
        repeat (9) @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        check("flush_mul_abort", 128'({stall_out, ex_valid}), 128'(0));
        repeat (40) @(negedge clock);
        send(4'b0000, 4'b0000, 2'b01, 32'd100, 32'd23, 32'd0, 10'd0, 5'd9);

        // Flush in IDLE drops the instruction presented with it.
        id_valid = 1'b1; EX_control = 4'b0000; busa = 32'd1; busb = 32'd2;
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0; id_valid = 1'b0;
        check("flush_drop", 128'(ex_valid), 128'(0));
        @(negedge clock);

        // Reset mid-multiply clears held results asynchronously.
        send(4'b0011, 4'b0101, 2'b11, 32'hA5A5_0000, 32'h0000_5A5A, 32'd0, 10'd77, 5'd10);
        send(4'b0111, 4'b0000, 2'b01, 32'd77, 32'd99, 32'd0, 10'd0, 5'd11);
        void'(exp_q.pop_back());
        repeat (5) @(negedge clock);
        #2 reset = 1'b1;
        #1 check("reset_mid_mul", 128'({out_vec, ex_valid, stall_out}), 128'(0));
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        send(4'b0000, 4'b0000, 2'b01, 32'd40, 32'd2, 32'd0, 10'd0, 5'd12);

        // Reset while a valid result is being presented.
        #2 reset = 1'b1;
        #1 check("reset_with_valid", 128'({out_vec, ex_valid, stall_out}), 128'(0));
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Random traffic, back-to-back where the gap is zero.
        for (int i = 0; i < 80; i++) begin
            op = 3'($urandom_range(0, 7));
            a = $urandom();
            b = ($urandom_range(0, 3) == 0) ? a : $urandom();
            if (op == 3'd6 && $urandom_range(0, 1) == 1) b = 32'($urandom_range(0, 31));
            send({1'($urandom_range(0, 1)), op}, 4'($urandom_range(0, 15)),
                 2'($urandom_range(0, 3)), a, b, $urandom(), 10'($urandom_range(0, 1023)),
                 5'($urandom_range(0, 31)));
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end

        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clock);
            n++;
        end
        check("queue_drained", 128'(exp_q.size()), 128'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
